// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types, handshake constants and width helper for add_accum.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } add_accum_state_t;

  localparam logic HOLD_READY = 1'b0;
  localparam logic IDLE_VALID = 1'b0;

  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/add_accum_ctrl.sv
// rtl/add_accum_ctrl.sv - batch FSM and counter; emits handshake and datapath strobes.
module add_accum_ctrl
  import add_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic in_valid,
  input  logic sum_ready,
  output logic in_ready,
  output logic sum_valid,
  output logic acc_load,
  output logic acc_zero,
  output logic batch_done
);

  localparam int CW = cnt_width(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  add_accum_state_t state;
  logic [CW-1:0]    cnt;

  assign in_ready   = (state == HOLD) ? HOLD_READY : !reset;
  assign acc_load   = in_valid && in_ready && !clear;
  assign batch_done = acc_load && (cnt == LAST);
  // clear outranks the output handshake, so both zero the datapath
  assign acc_zero   = clear || (sum_valid && sum_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sum_valid <= IDLE_VALID;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      sum_valid <= IDLE_VALID;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (acc_load) begin
            cnt <= cnt + CW'(1);
            if (batch_done) begin
              state     <= HOLD;
              sum_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state     <= IDLE;
            cnt       <= '0;
            sum_valid <= IDLE_VALID;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          sum_valid <= IDLE_VALID;
        end
      endcase
    end
  end

endmodule

// File: rtl/add_accum.sv
// rtl/add_accum.sv - sums COUNT adder results per batch; ADD_ACCUM_SAT_EN selects saturation over wrap.
module add_accum
  import add_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = WIDTH + $clog2(COUNT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [ACC_WIDTH-1:0] sum_data,
  output logic                 sum_ovf
);

  logic                 acc_load;
  logic                 acc_zero;
  logic                 batch_done;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic [ACC_WIDTH:0]   nxt;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 ovf_nxt;

  add_accum_ctrl #(.COUNT(COUNT)) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .sum_ready  (sum_ready),
    .in_ready   (in_ready),
    .sum_valid  (sum_valid),
    .acc_load   (acc_load),
    .acc_zero   (acc_zero),
    .batch_done (batch_done)
  );

  assign nxt     = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
  assign ovf_nxt = ovf | nxt[ACC_WIDTH];

`ifdef ADD_ACCUM_SAT_EN
  // once a batch has overflowed it stays pinned at full scale
  assign acc_nxt = ovf_nxt ? {ACC_WIDTH{1'b1}} : nxt[ACC_WIDTH-1:0];
`else
  assign acc_nxt = nxt[ACC_WIDTH-1:0];
`endif

  // sum_data/sum_ovf are captured only on batch completion so they hold through HOLD
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      ovf      <= 1'b0;
      sum_data <= '0;
      sum_ovf  <= 1'b0;
    end else if (acc_zero) begin
      acc      <= '0;
      ovf      <= 1'b0;
      sum_data <= '0;
      sum_ovf  <= 1'b0;
    end else if (acc_load) begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
      if (batch_done) begin
        sum_data <= acc_nxt;
        sum_ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_add_accum.sv
// tb/tb_add_accum.sv - self-checking bench for add_accum (COUNT=4 wide and 8-bit sums, COUNT=1).
module tb_add_accum;

`ifdef ADD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       sum_ready = 1'b0;

  logic       rdy_a, sv_a, so_a;
  logic [9:0] sd_a;
  logic       rdy_8, sv_8, so_8;
  logic [7:0] sd_8;
  logic       rdy_1, sv_1, so_1;
  logic [7:0] sd_1;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  add_accum #(.WIDTH(8), .COUNT(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .sum_valid(sv_a), .sum_ready(sum_ready), .sum_data(sd_a), .sum_ovf(so_a)
  );

  add_accum #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_8),
    .in_data(in_data), .sum_valid(sv_8), .sum_ready(sum_ready), .sum_data(sd_8), .sum_ovf(so_8)
  );

  add_accum #(.WIDTH(8), .COUNT(1)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy_1),
    .in_data(in_data), .sum_valid(sv_1), .sum_ready(sum_ready), .sum_data(sd_1), .sum_ovf(so_1)
  );

  typedef struct {
    int d[4];
    int e10;
    int e8w;
    int e8s;
    bit o8;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // batch result from the arithmetic rules: running total, flag on first excess
  function automatic longint model_sum(input int q[$], input int aw, input bit sat,
                                       output bit ovf);
    longint s = 0;
    longint mx = (longint'(1) << aw) - 1;
    ovf = 1'b0;
    foreach (q[i]) begin
      s += q[i];
      if (s > mx) ovf = 1'b1;
    end
    if (sat && ovf) return mx;
    return s % (mx + 1);
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; sum_ready = 1'b0; clear = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic feed(input int d[4], input bit rdy);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("feed_in_ready", rdy_a, 1);
      in_valid = 1'b1; in_data = 8'(d[i]); sum_ready = rdy;
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  initial begin
    int q[$];
    bit holding;
    longint exp10, exp8;
    bit o10, o8m;
    bit vld, rdy, clr;
    logic [7:0] dat;

    tbl[0].d = '{6, 1, 7, 3};         tbl[0].e10 = 17;   tbl[0].e8w = 17;  tbl[0].e8s = 17;  tbl[0].o8 = 0;
    tbl[1].d = '{200, 100, 0, 0};     tbl[1].e10 = 300;  tbl[1].e8w = 44;  tbl[1].e8s = 255; tbl[1].o8 = 1;
    tbl[2].d = '{255, 255, 255, 255}; tbl[2].e10 = 1020; tbl[2].e8w = 252; tbl[2].e8s = 255; tbl[2].o8 = 1;
    tbl[3].d = '{0, 0, 0, 0};         tbl[3].e10 = 0;    tbl[3].e8w = 0;   tbl[3].e8s = 0;   tbl[3].o8 = 0;
    tbl[4].d = '{128, 128, 0, 1};     tbl[4].e10 = 257;  tbl[4].e8w = 1;   tbl[4].e8s = 255; tbl[4].o8 = 1;

    #2;
    check("rst_in_ready", rdy_a, 0);
    check("rst_sum_valid", sv_a, 0);
    check("rst_sum_data", sd_a, 0);
    check("rst_sum_ovf", so_a, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("post_rst_in_ready", rdy_a, 1);

    // table-driven batches, sink always ready
    foreach (tbl[k]) begin
      feed(tbl[k].d, 1'b1);
      check("tbl_sum_valid", sv_a, 1);
      check("tbl_sum_data", sd_a, tbl[k].e10);
      check("tbl_sum_ovf", so_a, 0);
      check("tbl_hold_in_ready", rdy_a, 0);
      check("tbl8_sum_valid", sv_8, 1);
      check("tbl8_sum_data", sd_8, SAT ? tbl[k].e8s : tbl[k].e8w);
      check("tbl8_sum_ovf", so_8, tbl[k].o8);
      @(negedge clock);
      check("tbl_one_cycle_valid", sv_a, 0);
    end

    // backpressure
    feed('{6, 1, 7, 3}, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_sum_valid", sv_a, 1);
      check("bp_sum_data", sd_a, 17);
      check("bp_in_ready", rdy_a, 0);
      in_valid = 1'b1; in_data = 8'($urandom); sum_ready = 1'b0;
      @(negedge clock);
    end
    check("bp_final_data", sd_a, 17);
    in_valid = 1'b0; sum_ready = 1'b1;
    @(negedge clock);
    check("bp_released", sv_a, 0);
    feed('{1, 1, 1, 1}, 1'b1);
    check("bp_next_data", sd_a, 4);
    check("bp_next_valid", sv_a, 1);
    @(negedge clock);

    // asynchronous reset mid-batch
    in_valid = 1'b1; in_data = 8'd9;
    @(negedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("amid_in_ready", rdy_a, 0);
    check("amid_sum_valid", sv_a, 0);
    check("amid_sum_data", sd_a, 0);
    check("amid_sum_ovf", so_a, 0);
    #1 reset = 1'b0;
    feed('{2, 2, 2, 2}, 1'b1);
    check("amid_next_data", sd_a, 8);
    @(negedge clock);

    // clear in HOLD beats the handshake, clear in ACCUM drops partial sum and current input
    feed('{6, 1, 7, 3}, 1'b0);
    check("clr_hold_valid", sv_a, 1);
    clear = 1'b1; sum_ready = 1'b1; in_valid = 1'b1; in_data = 8'd9;
    @(negedge clock);
    check("clr_hold_dropped", sv_a, 0);
    check("clr_hold_data", sd_a, 0);
    check("clr_in_ready", rdy_a, 1);
    clear = 1'b0; in_data = 8'd7;
    @(negedge clock);
    in_data = 8'd8;
    @(negedge clock);
    clear = 1'b1; in_data = 8'd50;
    @(negedge clock);
    clear = 1'b0; in_valid = 1'b0;
    feed('{5, 5, 5, 5}, 1'b1);
    check("clr_accum_data", sd_a, 20);
    check("clr_accum_valid", sv_a, 1);
    @(negedge clock);

    // COUNT=1 with in_valid held high
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("c1_in_ready", rdy_1, 1);
      in_valid = 1'b1; in_data = 8'(3 + k); sum_ready = 1'b1;
      @(negedge clock);
      check("c1_sum_valid", sv_1, 1);
      check("c1_sum_data", sd_1, 3 + k);
      check("c1_gap_in_ready", rdy_1, 0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("c1_done_valid", sv_1, 0);

    // random traffic against the batch model
    do_reset();
    holding = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      check("rnd_sum_valid", sv_a, holding);
      check("rnd_in_ready", rdy_a, !holding);
      check("rnd8_sum_valid", sv_8, holding);
      if (holding) begin
        check("rnd_sum_data", sd_a, exp10);
        check("rnd_sum_ovf", so_a, o10);
        check("rnd8_sum_data", sd_8, exp8);
        check("rnd8_sum_ovf", so_8, o8m);
      end
      vld = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      dat = 8'($urandom);
      in_valid = vld; in_data = dat; sum_ready = rdy; clear = clr;
      if (clr) begin
        holding = 1'b0;
        q.delete();
      end else if (holding) begin
        if (rdy) holding = 1'b0;
      end else if (vld) begin
        q.push_back(int'(dat));
        if (q.size() == 4) begin
          exp10 = model_sum(q, 10, SAT, o10);
          exp8  = model_sum(q, 8, SAT, o8m);
          holding = 1'b1;
          q.delete();
        end
      end
    end
    @(negedge clock);
    clear = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
